// File: rtl/shift_ctl_pkg.sv
// Shared types and constants for the arbitrated multi-pass left shifter.
package shift_ctl_pkg;

  localparam int unsigned DW_DEF   = 64;
  localparam int unsigned AW_DEF   = 6;
  localparam int unsigned SAW      = 5;   // per-pass shifter amount width
  localparam int unsigned PASS_BIG = 16;  // fixed amount of the two extra passes
  localparam int unsigned PASS_CW  = 2;   // pass counter width (max 3 passes)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/barrel_shift_left.sv
// Logarithmic left barrel shifter with zero fill, one stage per amount bit.
module barrel_shift_left #(
  parameter int unsigned DW = 64,
  parameter int unsigned SW = 5
) (
  input  logic [DW-1:0] data_i,
  input  logic [SW-1:0] amt_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] stage [SW+1];

  assign stage[0] = data_i;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    assign stage[k+1] = amt_i[k] ? (stage[k] << (1 << k)) : stage[k];
  end

  assign data_o = stage[SW];

endmodule

// File: rtl/shift_arb_seq.sv
// Two-requester round-robin front end feeding a multi-pass 5-bit left shifter;
// amounts of 32 or more are split into passes of 16, 16 and the low five bits.
module shift_arb_seq
  import shift_ctl_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_data,
  input  logic [AW-1:0] req0_amt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_data,
  input  logic [AW-1:0] req1_amt,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id,
  output logic          busy
);

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic [DW-1:0]        w_q, w_d;
  logic                 id_q, id_d;
  logic [PASS_CW-1:0]   pass_q, pass_d;
  logic [SAW-1:0]       low_q, low_d;

  logic [SAW-1:0]       samt;
  logic [DW-1:0]        w_shifted;
  logic                 grant0, grant1;
  logic [AW-1:0]        amt_sel;

  // Extra passes run at the fixed amount; the final pass uses the low bits.
  assign samt = (pass_q > PASS_CW'(1)) ? SAW'(PASS_BIG) : low_q;

  barrel_shift_left #(
    .DW (DW),
    .SW (SAW)
  ) u_shift (
    .data_i (w_q),
    .amt_i  (samt),
    .data_o (w_shifted)
  );

  // Round robin: on a tie the requester that did not win last time is granted.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = !rst && (state_q == ST_IDLE) && grant0;
  assign req1_ready = !rst && (state_q == ST_IDLE) && grant1;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = w_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    w_d     = w_q;
    id_d    = id_q;
    pass_d  = pass_q;
    low_d   = low_q;
    amt_sel = grant1 ? req1_amt : req0_amt;
    unique case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          w_d     = grant1 ? req1_data : req0_data;
          id_d    = grant1;
          last_d  = grant1;
          low_d   = amt_sel[SAW-1:0];
          pass_d  = amt_sel[AW-1] ? PASS_CW'(3) : PASS_CW'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_d    = w_shifted;
        pass_d = pass_q - PASS_CW'(1);
        if (pass_q == PASS_CW'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      w_q     <= '0;
      id_q    <= 1'b0;
      pass_q  <= '0;
      low_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      w_q     <= w_d;
      id_q    <= id_d;
      pass_q  <= pass_d;
      low_q   <= low_d;
    end
  end

endmodule

// File: tb/tb_shift_arb_seq.sv
// Random and directed stimulus against a transaction-level model of the shifter.
module tb_shift_arb_seq;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_data, req1_data, rsp_data;
  logic [AW-1:0] req0_amt, req1_amt;
  logic          rsp_valid, rsp_ready, rsp_id, busy;

  always #5 clk = ~clk;

  shift_arb_seq #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: 0 = waiting for a request, 1 = computing (m_left cycles to go), 2 = holding result
  int            m_mode = 0;
  int            m_left = 0;
  logic [DW-1:0] m_data = '0;
  logic          m_id   = 1'b0;
  logic          m_last = 1'b1;
  int            grants[$];

  // One clock cycle: inputs already driven after a falling edge; checks, then edge.
  task automatic step(output logic acc0, output logic acc1);
    logic e0, e1;
    #1;
    if (rst) begin
      m_mode = 0; m_left = 0; m_data = '0; m_id = 1'b0; m_last = 1'b1;
    end
    e0 = 1'b0; e1 = 1'b0;
    if (!rst && m_mode == 0) begin
      if (req0_valid && req1_valid) begin
        e0 = m_last; e1 = !m_last;
      end else begin
        e0 = req0_valid; e1 = req1_valid;
      end
    end
    check("req0_ready", 64'(req0_ready), 64'(e0));
    check("req1_ready", 64'(req1_ready), 64'(e1));
    check("rsp_valid",  64'(rsp_valid),  64'(m_mode == 2));
    check("busy",       64'(busy),       64'(m_mode != 0));
    if (m_mode == 2 || rst) begin
      check("rsp_data", rsp_data,     m_data);
      check("rsp_id",   64'(rsp_id),  64'(m_id));
    end
    acc0 = e0; acc1 = e1;
    @(posedge clk);
    if (!rst) begin
      if (m_mode == 0 && (e0 || e1)) begin
        m_id   = e1;
        m_last = e1;
        m_data = e1 ? (req1_data << req1_amt) : (req0_data << req0_amt);
        m_left = ((e1 ? req1_amt : req0_amt) >= 6'd32) ? 3 : 1;
        m_mode = 1;
        grants.push_back(e1 ? 1 : 0);
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end else if (m_mode == 2 && rsp_ready) begin
        m_mode = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] pick_amt();
    logic [AW-1:0] corner [6];
    corner[0] = 6'd0; corner[1] = 6'd31; corner[2] = 6'd32;
    corner[3] = 6'd63; corner[4] = 6'd16; corner[5] = 6'd48;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return AW'($urandom_range(0, 63));
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {32'($urandom), 32'($urandom)};
  endfunction

  logic a0, a1;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0;
    @(negedge clk);
    step(a0, a1);
    step(a0, a1);
    rst = 1'b0;
    step(a0, a1);

    // req0: 1 << 5, single pass
    req0_valid = 1'b1; req0_data = 64'h1; req0_amt = 6'd5;
    step(a0, a1);
    check("acc_r0_a5", 64'(a0), 64'd1);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) step(a0, a1);

    // req1: 1 << 63, three passes
    req1_valid = 1'b1; req1_data = 64'h1; req1_amt = 6'd63;
    step(a0, a1);
    req1_valid = 1'b0;
    repeat (3) step(a0, a1);
    check("a63_result", rsp_data, 64'h8000_0000_0000_0000);
    check("a63_id", 64'(rsp_id), 64'd1);
    step(a0, a1);

    // amt 0 passes data through; response held 5 cycles without ready
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 64'hDEAD_BEEF; req0_amt = 6'd0;
    step(a0, a1);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 64'h3; req1_amt = 6'd2;
    repeat (6) step(a0, a1);
    check("a0_result", rsp_data, 64'hDEAD_BEEF);
    rsp_ready = 1'b1;
    repeat (4) step(a0, a1);
    req1_valid = 1'b0;
    repeat (2) step(a0, a1);

    // both valid continuously: grants must alternate
    grants.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_amt = 6'd1; req1_amt = 6'd1;
    for (int i = 0; i < 16; i++) begin
      req0_data = rand_data(); req1_data = rand_data();
      step(a0, a1);
      if (a0) req0_data = rand_data();
    end
    check("alt_count", 64'(grants.size() >= 4), 64'd1);
    for (int i = 1; i < grants.size(); i++)
      check("alt_order", 64'(grants[i]), 64'(1 - grants[i-1]));
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step(a0, a1);

    // reset during second pass of amt 40, then first tie goes to req0
    req1_valid = 1'b1; req1_data = 64'h5; req1_amt = 6'd40;
    step(a0, a1);
    req1_valid = 1'b0;
    step(a0, a1);
    rst = 1'b1;
    step(a0, a1);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 64'h7; req1_data = 64'h9; req0_amt = 6'd3; req1_amt = 6'd3;
    step(a0, a1);
    check("rst_tie_req0", 64'(a0), 64'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step(a0, a1);

    // random traffic with hold-until-ready requesters and occasional drops
    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; req0_data = rand_data(); req0_amt = pick_amt();
      end else if (req0_valid && $urandom_range(0, 40) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; req1_data = rand_data(); req1_amt = pick_amt();
      end else if (req1_valid && $urandom_range(0, 40) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      step(a0, a1);
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
